shift_pipeline_arbiter: RTL and testbench
=========================================

# shift_pipeline_arbiter

Two-requester round-robin arbiter and sequencer for the 3-stage variable left-shift pipeline. Each cycle it grants at most one requester and drives that requester's operand and shift width into the shifter. It tracks the owner of every in-flight operation with a tag pipeline matched to the shifter latency. It returns each result to its owner with a one-cycle valid pulse. It sits between the two client blocks and the shared shifter instance.

## Interface
- DATA_W, 8, operand and result width
- WIDTH_W, 3, shift-width field width (log2 DATA_W)
- LATENCY, 3, shifter latency in clock edges from issue to `sh_result`
- CLK  input  1  clock, rising edge
- RST  input  1  reset; synchronous, active-high
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 granted this cycle
- req0_data  input  DATA_W  requester 0 operand
- req0_width  input  WIDTH_W  requester 0 shift amount
- req1_valid / req1_ready / req1_data / req1_width: same as requester 0, for requester 1
- sh_a  output  DATA_W  operand to shifter
- sh_width  output  WIDTH_W  shift amount to shifter
- sh_result  input  DATA_W  shifter output
- rsp0_valid  output  1  `rsp_data` belongs to requester 0 this cycle
- rsp1_valid  output  1  `rsp_data` belongs to requester 1 this cycle
- rsp_data  output  DATA_W  result, equal to `sh_result`
- busy  output  1  at least one operation in flight

## Operation
- Transfer happens when `reqN_valid && reqN_ready` in the same cycle. Ready is combinational from valid and the arbitration pointer.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: the requester named by `ptr` is granted.
  - Neither valid: no grant.
- `ptr` (1 bit, reset 0) updates on every grant to point at the requester that was not granted. An uncontested stream from one requester therefore leaves `ptr` pointing at the other.
- Issue cycle: `sh_a`/`sh_width` = granted requester's data/width.
- Idle cycle: `sh_a` = 0, `sh_width` = 0.
- Tag pipeline: LATENCY stages of {valid, id}. Stage 1 loads {grant, granted id} each edge; every stage shifts each edge. There is no stall, and the shifter never stalls.
- Response outputs:
  - `rsp0_valid` = last-stage valid && id==0.
  - `rsp1_valid` = last-stage valid && id==1.
  - `rsp_data` = `sh_result` unconditionally; meaningful only while a `rspN_valid` is high.
- At most one of `rsp0_valid`/`rsp1_valid` is high in any cycle. There is no response backpressure; clients must accept the pulse.
- `busy` = OR of all tag-stage valids.
- Result arithmetic is performed by the shifter, not here: result = operand << width, truncated to DATA_W. The block passes `sh_result` through unchanged.

## Timing
- Reset values (RST high at an edge): `ptr`=0, all tag valids 0.
  - With no request valid: `req0_ready`=0, `req1_ready`=0, `sh_a`=0, `sh_width`=0.
  - `rsp0_valid`=0, `rsp1_valid`=0, `busy`=0.
- While RST is high, no grant is issued; both readies are 0 regardless of valid.
- Throughput: one grant per cycle, back-to-back, with no bubble between requesters.
- Latency: grant in cycle T gives `rspN_valid` high in cycle T+LATENCY, exactly one cycle wide, with `rsp_data` = `sh_result` of that cycle.
- Reset mid-operation: all tag stages are cleared at the reset edge. Results of operations issued before reset are never reported, even though the shifter may still emit them. The first post-reset grant in cycle T responds at T+LATENCY.
- Simultaneous events: a new grant and a response in the same cycle are independent.
- Both requesters valid every cycle: grants alternate 0,1,0,1…
- A valid that drops before being granted is legal. Nothing is recorded and `ptr` does not change.

## Test plan
- Reset, then req0 alone, data 8'h81, width 1 -> `req0_ready`=1 that cycle; 3 cycles later `rsp0_valid`=1 with `rsp_data`=8'h02, `rsp1_valid`=0; `busy` is high for exactly 3 cycles.
- Both valid continuously for 6 cycles, req0 = 8'h01 width 0..5, req1 = 8'h03 width 7 -> grants 0,1,0,1,0,1 starting from requester 0; responses at +3 are 8'h01, 8'h80, 8'h04, 8'h80, 8'h10, 8'h80 with matching rsp ids.
- req1 alone for 4 cycles, then both valid -> `ptr`=0 after the req1 grants, so requester 0 wins the first contested cycle.
- Issue 3 back-to-back ops from alternating requesters, assert RST for 1 cycle on the cycle after the third issue -> no `rsp*_valid` is ever asserted for those ops; `busy`=0 right after reset; a new op issued after reset responds exactly 3 cycles later.
- Random valid patterns on both requesters over 2000 cycles, checked against a scoreboard model -> every granted op returns exactly once, to the correct owner, in issue order, with value (data << width) & 8'hFF, and never two rsp valids in one cycle.

Source files
------------

// File: rtl/shift_pipeline_arbiter.sv
`default_nettype none
// ============================================================================
// shift_pipeline_arbiter: two-requester round-robin front end for a fixed-
// latency left-shift pipeline, with owner tags returned alongside results.
// Revision: 1.0
// ============================================================================
module shift_pipeline_arbiter #(
   parameter int DATA_W  = 8,
   parameter int WIDTH_W = 3,
   parameter int LATENCY = 3
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [DATA_W-1:0]  req0_data,
   input  logic [WIDTH_W-1:0] req0_width,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [DATA_W-1:0]  req1_data,
   input  logic [WIDTH_W-1:0] req1_width,
   output logic [DATA_W-1:0]  sh_a,
   output logic [WIDTH_W-1:0] sh_width,
   input  logic [DATA_W-1:0]  sh_result,
   output logic               rsp0_valid,
   output logic               rsp1_valid,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               busy
);

   logic               ptr_q, ptr_d;
   logic [LATENCY-1:0] vld_q, vld_d;
   logic [LATENCY-1:0] id_q,  id_d;
   logic               gnt0, gnt1;

   always_comb begin
      gnt0  = 1'b0;
      gnt1  = 1'b0;
      ptr_d = ptr_q;
      vld_d = '0;
      id_d  = '0;

      // ptr names the winner only when both requesters contend
      if (!RST) begin
         if (req0_valid && (!req1_valid || !ptr_q))
            gnt0 = 1'b1;
         else if (req1_valid)
            gnt1 = 1'b1;
      end

      if (gnt0)
         ptr_d = 1'b1;
      else if (gnt1)
         ptr_d = 1'b0;

      vld_d[0] = gnt0 | gnt1;
      id_d[0]  = gnt1;
      for (int i = 1; i < LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         id_d[i]  = id_q[i-1];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q <= 1'b0;
         vld_q <= '0;
         id_q  <= '0;
      end else begin
         ptr_q <= ptr_d;
         vld_q <= vld_d;
         id_q  <= id_d;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_comb begin
      sh_a     = '0;
      sh_width = '0;
      if (gnt0) begin
         sh_a     = req0_data;
         sh_width = req0_width;
      end else if (gnt1) begin
         sh_a     = req1_data;
         sh_width = req1_width;
      end
   end

   // Responses are suppressed while reset is held so pre-reset ops never report
   assign rsp0_valid = !RST && vld_q[LATENCY-1] && !id_q[LATENCY-1];
   assign rsp1_valid = !RST && vld_q[LATENCY-1] &&  id_q[LATENCY-1];
   assign rsp_data   = sh_result;
   assign busy       = |vld_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_pipeline_arbiter.sv
`default_nettype none
// ============================================================================
// tb_shift_pipeline_arbiter: randomized and directed bench with a queue-based
// scoreboard and a behavioural 3-stage shifter. Revision: 1.0
// ============================================================================
module tb_shift_pipeline_arbiter;
   localparam int LAT = 3;

   logic       CLK = 1'b0;
   logic       RST;
   logic       req0_valid, req1_valid;
   logic       req0_ready, req1_ready;
   logic [7:0] req0_data, req1_data;
   logic [2:0] req0_width, req1_width;
   logic [7:0] sh_a, sh_result, rsp_data;
   logic [2:0] sh_width;
   logic       rsp0_valid, rsp1_valid, busy;

   shift_pipeline_arbiter #(.DATA_W(8), .WIDTH_W(3), .LATENCY(LAT)) dut (
      .CLK(CLK), .RST(RST),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_data(req0_data), .req0_width(req0_width),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_data(req1_data), .req1_width(req1_width),
      .sh_a(sh_a), .sh_width(sh_width), .sh_result(sh_result),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp_data(rsp_data), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // Shared shifter: never reset, keeps emitting whatever it was fed
   logic [7:0] s0, s1, s2;
   always_ff @(posedge CLK) begin
      s0 <= sh_a << sh_width;
      s1 <= s0;
      s2 <= s1;
   end
   assign sh_result = s2;

   typedef struct {
      int       due;
      bit       id;
      bit [7:0] val;
   } op_t;

   op_t      q[$];
   bit [7:0] rlog[$];
   bit       idlog[$];
   bit       m_fav1;
   int       cyc = 0;
   int       checks = 0;
   int       failures = 0;
   int       busy_cnt = 0;
   bit       last_r0, last_busy;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
      end
   endtask

   task automatic step(input bit r,
                       input bit v0, input bit [7:0] d0, input bit [2:0] w0,
                       input bit v1, input bit [7:0] d1, input bit [2:0] w1);
      bit g0, g1, e0, e1;
      bit [7:0] ev;
      int t;
      RST = r;
      req0_valid = v0; req0_data = d0; req0_width = w0;
      req1_valid = v1; req1_data = d1; req1_width = w1;
      @(negedge CLK);

      g0 = !r && v0 && (!v1 || !m_fav1);
      g1 = !r && v1 && !g0;
      check("req0_ready", req0_ready, g0);
      check("req1_ready", req1_ready, g1);
      check("sh_a", sh_a, g0 ? d0 : (g1 ? d1 : 8'h00));
      check("sh_width", sh_width, g0 ? w0 : (g1 ? w1 : 3'd0));
      check("busy", busy, q.size() != 0);
      last_r0   = req0_ready;
      last_busy = busy;
      if (busy) busy_cnt++;

      e0 = 1'b0; e1 = 1'b0; ev = 8'h00;
      if (q.size() != 0 && q[0].due == cyc) begin
         if (!r) begin
            e0 = !q[0].id;
            e1 =  q[0].id;
            ev = q[0].val;
         end
         void'(q.pop_front());
      end
      check("rsp0_valid", rsp0_valid, e0);
      check("rsp1_valid", rsp1_valid, e1);
      check("rsp_onehot", rsp0_valid & rsp1_valid, 1'b0);
      if (e0 || e1) begin
         check("rsp_data", rsp_data, ev);
         rlog.push_back(rsp_data);
         idlog.push_back(rsp1_valid);
      end

      if (r) begin
         q.delete();
         m_fav1 = 1'b0;
      end else if (g0 || g1) begin
         t = g0 ? (int'(d0) << w0) : (int'(d1) << w1);
         q.push_back('{due: cyc + LAT, id: g1, val: t[7:0]});
         m_fav1 = g0;
      end

      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0);
   endtask

   bit [7:0] exp_vals [6];
   bit       exp_ids  [6];

   initial begin
      RST = 1'b1;
      req0_valid = 1'b0; req0_data = '0; req0_width = '0;
      req1_valid = 1'b0; req1_data = '0; req1_width = '0;
      m_fav1 = 1'b0;
      @(posedge CLK);
      #1;

      // Single op from requester 0
      do_reset(2);
      rlog.delete(); idlog.delete(); busy_cnt = 0;
      step(1'b0, 1'b1, 8'h81, 3'd1, 1'b0, 8'h00, 3'd0);
      check("t1_ready", last_r0, 1'b1);
      idle(5);
      check("t1_busy_cycles", busy_cnt, 3);
      check("t1_rsp_count", rlog.size(), 1);
      if (rlog.size() == 1) begin
         check("t1_rsp_data", rlog[0], 8'h02);
         check("t1_rsp_id", idlog[0], 1'b0);
      end

      // Continuous contention alternates starting from requester 0
      do_reset(1);
      rlog.delete(); idlog.delete();
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h01, 3'(i), 1'b1, 8'h03, 3'd7);
      idle(4);
      exp_vals = '{8'h01, 8'h80, 8'h04, 8'h80, 8'h10, 8'h80};
      exp_ids  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      check("t2_rsp_count", rlog.size(), 6);
      if (rlog.size() == 6) begin
         for (int i = 0; i < 6; i++) begin
            check("t2_rsp_data", rlog[i], exp_vals[i]);
            check("t2_rsp_id", idlog[i], exp_ids[i]);
         end
      end

      // Uncontested requester 1 leaves the pointer on requester 0
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 8'(i + 1), 3'd1);
      step(1'b0, 1'b1, 8'h11, 3'd2, 1'b1, 8'h22, 3'd3);
      check("t3_req0_wins", last_r0, 1'b1);
      idle(4);

      // Reset while ops are in flight discards them
      rlog.delete(); idlog.delete();
      step(1'b0, 1'b1, 8'h0F, 3'd1, 1'b0, 8'h00, 3'd0);
      step(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 8'hF0, 3'd2);
      step(1'b0, 1'b1, 8'h33, 3'd3, 1'b0, 8'h00, 3'd0);
      do_reset(1);
      idle(1);
      check("t4_busy_after_rst", last_busy, 1'b0);
      idle(3);
      check("t4_no_stale_rsp", rlog.size(), 0);
      step(1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 8'h05, 3'd2);
      idle(4);
      check("t4_new_rsp_count", rlog.size(), 1);
      if (rlog.size() == 1) begin
         check("t4_new_rsp_data", rlog[0], 8'h14);
         check("t4_new_rsp_id", idlog[0], 1'b1);
      end

      // Random traffic with rare mid-stream resets
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 9) < 6, 8'($urandom), 3'($urandom),
              $urandom_range(0, 9) < 6, 8'($urandom), 3'($urandom));
      end
      idle(LAT + 2);
      check("drain_empty", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
